// File: rtl/branch_resolve.sv
// Branch resolution queue: tracks in-flight predicted branches in fetch order,
// compares each against its execute outcome, and produces the predictor
// update bundle, the fetch redirect and resolution statistics.
module branch_resolve #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic        push_pred_taken,
  input  logic [31:0] push_pred_target,
  output logic        full,
  input  logic        res_valid,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic        empty,
  input  logic        flush,
  output logic        enable_res,
  output logic [31:0] pc_res,
  output logic        taken_res,
  output logic [31:0] bt_res,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [15:0] resolved_cnt,
  output logic [15:0] mispred_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Entry storage (datapath only, no reset needed)
  logic [31:0] r_pc   [DEPTH];
  logic        r_pt   [DEPTH];
  logic [31:0] r_ptgt [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic        r_enable_res;
  logic [31:0] r_pc_res;
  logic        r_taken_res;
  logic [31:0] r_bt_res;
  logic        r_mispredict;
  logic [31:0] r_redirect_pc;
  logic [15:0] r_resolved_cnt;
  logic [15:0] r_mispred_cnt;

  logic        w_full;
  logic        w_empty;
  logic        w_res_fire;
  logic        w_push_fire;
  logic        w_mispred;
  logic        w_clear;
  logic [31:0] w_head_pc;
  logic        w_head_pt;
  logic [31:0] w_head_tgt;
  logic [31:0] w_redirect;

  // Occupancy decode, head entry read and resolution/push qualification
  always_comb begin
    w_full      = (r_count == FULL_CNT);
    w_empty     = (r_count == '0);
    w_head_pc   = r_pc[r_head];
    w_head_pt   = r_pt[r_head];
    w_head_tgt  = r_ptgt[r_head];
    w_res_fire  = res_valid && !w_empty && !flush;
    w_mispred   = w_res_fire &&
                  ((w_head_pt != res_taken) ||
                   (res_taken && (w_head_tgt != res_target)));
    w_clear     = flush || w_mispred;
    // A full queue still accepts a push when the head retires this cycle
    w_push_fire = push && !w_clear && (!w_full || w_res_fire);
    w_redirect  = res_taken ? res_target : (w_head_pc + 32'd4);
  end

  // Entry write at the tail
  always_ff @(posedge CLK) begin
    if (w_push_fire) begin
      r_pc[r_tail]   <= push_pc;
      r_pt[r_tail]   <= push_pred_taken;
      r_ptgt[r_tail] <= push_pred_target;
    end
  end

  // Pointers and occupancy; flush or mispredict empties the queue
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_res_fire)  r_head <= r_head + PTR_W'(1);
      if (w_push_fire) r_tail <= r_tail + PTR_W'(1);
      case ({w_push_fire, w_res_fire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Update bundle and redirect: single-cycle pulses, payload held otherwise
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_enable_res  <= 1'b0;
      r_pc_res      <= '0;
      r_taken_res   <= 1'b0;
      r_bt_res      <= '0;
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_enable_res <= w_res_fire;
      r_mispredict <= w_mispred;
      if (w_res_fire) begin
        r_pc_res    <= w_head_pc;
        r_taken_res <= res_taken;
        r_bt_res    <= res_target;
      end
      if (w_mispred) r_redirect_pc <= w_redirect;
    end
  end

  // Saturating statistics counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_resolved_cnt <= '0;
      r_mispred_cnt  <= '0;
    end else begin
      if (w_res_fire && (r_resolved_cnt != CNT_MAX))
        r_resolved_cnt <= r_resolved_cnt + 16'd1;
      if (w_mispred && (r_mispred_cnt != CNT_MAX))
        r_mispred_cnt <= r_mispred_cnt + 16'd1;
    end
  end

  assign full         = w_full;
  assign empty        = w_empty;
  assign enable_res   = r_enable_res;
  assign pc_res       = r_pc_res;
  assign taken_res    = r_taken_res;
  assign bt_res       = r_bt_res;
  assign mispredict   = r_mispredict;
  assign redirect_pc  = r_redirect_pc;
  assign resolved_cnt = r_resolved_cnt;
  assign mispred_cnt  = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: vector table plus multi-cycle sequences.
module tb_branch_resolve;

  logic        CLK;
  logic        nRST;
  logic        push;
  logic [31:0] push_pc;
  logic        push_pred_taken;
  logic [31:0] push_pred_target;
  logic        full;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        empty;
  logic        flush;
  logic        enable_res;
  logic [31:0] pc_res;
  logic        taken_res;
  logic [31:0] bt_res;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] resolved_cnt;
  logic [15:0] mispred_cnt;

  int n_cmp;
  int n_fail;

  branch_resolve #(.DEPTH(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .push(push), .push_pc(push_pc), .push_pred_taken(push_pred_taken),
    .push_pred_target(push_pred_target), .full(full),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .empty(empty), .flush(flush),
    .enable_res(enable_res), .pc_res(pc_res), .taken_res(taken_res), .bt_res(bt_res),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .resolved_cnt(resolved_cnt), .mispred_cnt(mispred_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        p;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        rv;
    logic        rt;
    logic [31:0] rtgt;
    logic        fl;
    logic        e_en;
    logic [31:0] e_pc;
    logic        e_tk;
    logic [31:0] e_bt;
    logic        e_mis;
    logic [31:0] e_rd;
    logic        e_empty;
    logic        e_full;
    logic [15:0] e_rc;
    logic [15:0] e_mc;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [31:0] pc, input logic pt,
                       input logic [31:0] ptgt, input logic rv, input logic rt,
                       input logic [31:0] rtgt, input logic fl);
    push             = p;
    push_pc          = pc;
    push_pred_taken  = pt;
    push_pred_target = ptgt;
    res_valid        = rv;
    res_taken        = rt;
    res_target       = rtgt;
    flush            = fl;
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] head;
    logic [31:0] npc;
    logic [15:0] exp_rc;
    n_cmp  = 0;
    n_fail = 0;

    //          push pc            pt  ptgt          rv  rt  rtgt          fl | en  pc_res        tk  bt            mis redirect      emp ful rc     mc
    vecs[0]  = '{1'b1, 32'h100,      1'b1, 32'h140, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 16'd0, 16'd0};
    vecs[1]  = '{1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 1'b1, 32'h140, 1'b0, 1'b1, 32'h100,      1'b1, 32'h140, 1'b0, 32'h0,   1'b1, 1'b0, 16'd1, 16'd0};
    vecs[2]  = '{1'b1, 32'h200,      1'b0, 32'h204, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h100,      1'b1, 32'h140, 1'b0, 32'h0,   1'b0, 1'b0, 16'd1, 16'd0};
    vecs[3]  = '{1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 1'b1, 32'h180, 1'b0, 1'b1, 32'h200,      1'b1, 32'h180, 1'b1, 32'h180, 1'b1, 1'b0, 16'd2, 16'd1};
    vecs[4]  = '{1'b1, 32'h2F0,      1'b1, 32'h300, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h200,      1'b1, 32'h180, 1'b0, 32'h180, 1'b0, 1'b0, 16'd2, 16'd1};
    vecs[5]  = '{1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 1'b1, 32'h340, 1'b0, 1'b1, 32'h2F0,      1'b1, 32'h340, 1'b1, 32'h340, 1'b1, 1'b0, 16'd3, 16'd2};
    vecs[6]  = '{1'b1, 32'h400,      1'b1, 32'h480, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h2F0,      1'b1, 32'h340, 1'b0, 32'h340, 1'b0, 1'b0, 16'd3, 16'd2};
    vecs[7]  = '{1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 1'b0, 32'h480, 1'b0, 1'b1, 32'h400,      1'b0, 32'h480, 1'b1, 32'h404, 1'b1, 1'b0, 16'd4, 16'd3};
    vecs[8]  = '{1'b1, 32'h500,      1'b0, 32'h504, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h400,      1'b0, 32'h480, 1'b0, 32'h404, 1'b0, 1'b0, 16'd4, 16'd3};
    vecs[9]  = '{1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 1'b0, 32'h5F0, 1'b0, 1'b1, 32'h500,      1'b0, 32'h5F0, 1'b0, 32'h404, 1'b1, 1'b0, 16'd5, 16'd3};
    vecs[10] = '{1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 1'b1, 32'h999, 1'b0, 1'b0, 32'h500,      1'b0, 32'h5F0, 1'b0, 32'h404, 1'b1, 1'b0, 16'd5, 16'd3};
    vecs[11] = '{1'b1, 32'h600,      1'b0, 32'h604, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h500,      1'b0, 32'h5F0, 1'b0, 32'h404, 1'b0, 1'b0, 16'd5, 16'd3};
    vecs[12] = '{1'b1, 32'h800,      1'b0, 32'h804, 1'b1, 1'b1, 32'h700, 1'b0, 1'b1, 32'h600,      1'b1, 32'h700, 1'b1, 32'h700, 1'b1, 1'b0, 16'd6, 16'd4};
    vecs[13] = '{1'b1, 32'hFFFFFFFC, 1'b1, 32'h10,  1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h600,      1'b1, 32'h700, 1'b0, 32'h700, 1'b0, 1'b0, 16'd6, 16'd4};
    vecs[14] = '{1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 1'b0, 32'h10,  1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h10,  1'b1, 32'h0,   1'b1, 1'b0, 16'd7, 16'd5};

    // Reset state
    nRST = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1 nRST = 1'b0;
    #1;
    chk("rst_en", 32'(enable_res), 32'h0);
    chk("rst_mis", 32'(mispredict), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_rc", 32'(resolved_cnt), 32'h0);
    chk("rst_mc", 32'(mispred_cnt), 32'h0);
    cycle();
    cycle();
    nRST = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].p, vecs[i].pc, vecs[i].pt, vecs[i].ptgt,
            vecs[i].rv, vecs[i].rt, vecs[i].rtgt, vecs[i].fl);
      cycle();
      chk($sformatf("v%0d_en", i),    32'(enable_res),   32'(vecs[i].e_en));
      chk($sformatf("v%0d_pc", i),    pc_res,            vecs[i].e_pc);
      chk($sformatf("v%0d_tk", i),    32'(taken_res),    32'(vecs[i].e_tk));
      chk($sformatf("v%0d_bt", i),    bt_res,            vecs[i].e_bt);
      chk($sformatf("v%0d_mis", i),   32'(mispredict),   32'(vecs[i].e_mis));
      chk($sformatf("v%0d_rd", i),    redirect_pc,       vecs[i].e_rd);
      chk($sformatf("v%0d_empty", i), 32'(empty),        32'(vecs[i].e_empty));
      chk($sformatf("v%0d_full", i),  32'(full),         32'(vecs[i].e_full));
      chk($sformatf("v%0d_rc", i),    32'(resolved_cnt), 32'(vecs[i].e_rc));
      chk($sformatf("v%0d_mc", i),    32'(mispred_cnt),  32'(vecs[i].e_mc));
    end

    // Full, drop, simultaneous push/resolve and FIFO order across wrap
    exp_rc = 16'd7;
    for (int i = 0; i < 5; i++) begin
      npc = 32'h1000 + 32'(i) * 32'h10;
      drive(1'b1, npc, 1'b1, npc + 32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
      cycle();
      if (i < 4) exp_q.push_back(npc);
      chk($sformatf("fill%0d_full", i), 32'(full), (i >= 3) ? 32'h1 : 32'h0);
      chk($sformatf("fill%0d_en", i), 32'(enable_res), 32'h0);
    end
    for (int i = 5; i < 9; i++) begin
      npc  = 32'h1000 + 32'(i) * 32'h10;
      head = exp_q.pop_front();
      drive(1'b1, npc, 1'b1, npc + 32'h40, 1'b1, 1'b1, head + 32'h40, 1'b0);
      exp_q.push_back(npc);
      cycle();
      exp_rc++;
      chk($sformatf("pr%0d_en", i), 32'(enable_res), 32'h1);
      chk($sformatf("pr%0d_pc", i), pc_res, head);
      chk($sformatf("pr%0d_mis", i), 32'(mispredict), 32'h0);
      chk($sformatf("pr%0d_full", i), 32'(full), 32'h1);
      chk($sformatf("pr%0d_rc", i), 32'(resolved_cnt), 32'(exp_rc));
    end
    for (int i = 0; i < 4; i++) begin
      head = exp_q.pop_front();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, head + 32'h40, 1'b0);
      cycle();
      exp_rc++;
      chk($sformatf("dr%0d_en", i), 32'(enable_res), 32'h1);
      chk($sformatf("dr%0d_pc", i), pc_res, head);
      chk($sformatf("dr%0d_mis", i), 32'(mispredict), 32'h0);
      chk($sformatf("dr%0d_full", i), 32'(full), 32'h0);
      chk($sformatf("dr%0d_empty", i), 32'(empty), (i == 3) ? 32'h1 : 32'h0);
    end
    chk("dr_rc", 32'(resolved_cnt), 32'd15);
    chk("dr_mc", 32'(mispred_cnt), 32'd5);

    // Flush collides with resolution and push
    drive(1'b1, 32'h2000, 1'b0, 32'h2004, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle();
    drive(1'b1, 32'h2010, 1'b0, 32'h2014, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle();
    drive(1'b1, 32'h2020, 1'b0, 32'h2024, 1'b1, 1'b1, 32'h3000, 1'b1);
    cycle();
    chk("fl_en", 32'(enable_res), 32'h0);
    chk("fl_mis", 32'(mispredict), 32'h0);
    chk("fl_empty", 32'(empty), 32'h1);
    chk("fl_rc", 32'(resolved_cnt), 32'd15);
    chk("fl_mc", 32'(mispred_cnt), 32'd5);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3000, 1'b0);
    cycle();
    chk("fl_after_en", 32'(enable_res), 32'h0);
    chk("fl_after_pc_hold", pc_res, 32'h1080);
    chk("fl_after_rc", 32'(resolved_cnt), 32'd15);

    // Counter saturation from a preloaded value
    force dut.r_resolved_cnt = 16'hFFFE;
    force dut.r_mispred_cnt  = 16'hFFFE;
    #1;
    release dut.r_resolved_cnt;
    release dut.r_mispred_cnt;
    drive(1'b1, 32'h3000, 1'b0, 32'h3004, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle();
    chk("sat_pre_rc", 32'(resolved_cnt), 32'hFFFE);
    chk("sat_pre_mc", 32'(mispred_cnt), 32'hFFFE);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3100, 1'b0);
    cycle();
    chk("sat1_mis", 32'(mispredict), 32'h1);
    chk("sat1_rd", redirect_pc, 32'h3100);
    chk("sat1_rc", 32'(resolved_cnt), 32'hFFFF);
    chk("sat1_mc", 32'(mispred_cnt), 32'hFFFF);
    drive(1'b1, 32'h3010, 1'b0, 32'h3014, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3200, 1'b0);
    cycle();
    chk("sat2_mis", 32'(mispredict), 32'h1);
    chk("sat2_rc", 32'(resolved_cnt), 32'hFFFF);
    chk("sat2_mc", 32'(mispred_cnt), 32'hFFFF);

    // Reset asserted mid-stream
    drive(1'b1, 32'h4000, 1'b0, 32'h4004, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle();
    drive(1'b1, 32'h4010, 1'b0, 32'h4014, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4004, 1'b0);
    cycle();
    chk("mid_en", 32'(enable_res), 32'h1);
    chk("mid_pc", pc_res, 32'h4000);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4014, 1'b0);
    #2 nRST = 1'b0;
    #1;
    chk("arst_en", 32'(enable_res), 32'h0);
    chk("arst_pc", pc_res, 32'h0);
    chk("arst_tk", 32'(taken_res), 32'h0);
    chk("arst_bt", bt_res, 32'h0);
    chk("arst_mis", 32'(mispredict), 32'h0);
    chk("arst_rd", redirect_pc, 32'h0);
    chk("arst_rc", 32'(resolved_cnt), 32'h0);
    chk("arst_mc", 32'(mispred_cnt), 32'h0);
    chk("arst_empty", 32'(empty), 32'h1);
    chk("arst_full", 32'(full), 32'h0);
    cycle();
    nRST = 1'b1;
    cycle();
    chk("post_rst_en", 32'(enable_res), 32'h0);
    chk("post_rst_mis", 32'(mispredict), 32'h0);
    chk("post_rst_empty", 32'(empty), 32'h1);
    chk("post_rst_rc", 32'(resolved_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of in-flight prediction entries (power of two, 2..16).
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port push  input  1  fetch records one predicted branch this cycle.
REQ-005 SHALL have port push_pc  input  32  PC of the pushed branch.
REQ-006 SHALL have port push_pred_taken  input  1  direction predicted at fetch.
REQ-007 SHALL have port push_pred_target  input  32  next PC the fetch stage chose (target if taken, else PC+4).
REQ-008 SHALL have port full  output  1  queue holds DEPTH entries.
REQ-009 SHALL have port res_valid  input  1  execute presents the outcome of the oldest branch.
REQ-010 SHALL have port res_taken  input  1  actual direction.
REQ-011 SHALL have port res_target  input  32  actual computed branch target.
REQ-012 SHALL have port empty  output  1  queue holds no entries.
REQ-013 SHALL have port flush  input  1  external pipeline flush (exception/trap).
REQ-014 SHALL have ports enable_res  output  1, pc_res  output  32, taken_res  output  1 and bt_res  output  32, forming the predictor update bundle.
REQ-015 SHALL have ports mispredict  output  1 and redirect_pc  output  32, forming the fetch redirect.
REQ-016 SHALL have ports resolved_cnt  output  16 and mispred_cnt  output  16, the statistics counters.

Function
REQ-017 Queue SHALL be a circular buffer with head/tail pointers wrapping modulo DEPTH; full/empty SHALL come from an occupancy count, and count SHALL never exceed DEPTH or go below 0.
REQ-018 A push SHALL be accepted when push=1 and full=0; a push while full SHALL be dropped with no state change.
REQ-019 A resolution SHALL be consumed when res_valid=1 and empty=0; res_valid while empty SHALL be ignored and produce no outputs.
REQ-020 A simultaneous push and resolution SHALL be allowed, including when full (push accepted, count unchanged), except as limited by REQ-023 and REQ-024.
REQ-021 A consumed resolution SHALL be mispredicted if head.pred_taken != res_taken, or if res_taken=1 and head.pred_target != res_target.
REQ-022 Latency SHALL be one cycle: the edge that consumes a resolution SHALL register enable_res=1, pc_res=head.pc, taken_res=res_taken, bt_res=res_target; mispredict=1 SHALL also be registered on that edge when applicable, with redirect_pc = res_taken ? res_target : head.pc+4 (32-bit, wraps). Each of these is a single-cycle pulse, 0 otherwise.
REQ-023 On mispredict, the same edge SHALL clear the queue (pointers and count to 0); a push in that cycle SHALL be dropped as wrong-path.
REQ-024 flush=1 SHALL clear the queue on that edge, discard any resolution and push in that cycle, and emit no enable_res or mispredict pulse; flush takes priority over everything.
REQ-025 enable_res SHALL pulse for every consumed resolution, correct or not.
REQ-026 resolved_cnt SHALL increment per consumed resolution and mispred_cnt per mispredict; both SHALL saturate at 16'hFFFF.
REQ-027 Pulse outputs SHALL hold their previous bundle values (pc_res, taken_res, bt_res, redirect_pc) when not pulsing.

Reset
REQ-028 nRST=0 SHALL asynchronously clear the pointers, count, counters and all outputs to 0, giving empty=1 and full=0.
REQ-029 Reset mid-operation SHALL discard all in-flight entries; no pulse SHALL be emitted in the first cycle after release.

Verification
REQ-030 The bench SHALL cover correct taken: push pc=0x100, pred_taken=1, target=0x140; resolve taken, 0x140 -> next cycle enable_res=1, pc_res=0x100, bt_res=0x140, mispredict=0, resolved_cnt=1.
REQ-031 The bench SHALL cover direction miss: push pc=0x200, pred_taken=0, target=0x204; resolve taken, 0x180 -> mispredict=1, redirect_pc=0x180, queue empty, mispred_cnt=1.
REQ-032 The bench SHALL cover target miss: pred_taken=1, target 0x300; resolve taken, 0x340 -> mispredict=1, redirect_pc=0x340.
REQ-033 The bench SHALL cover full and wrap: push 5 entries with DEPTH=4 -> 5th dropped, full=1; simultaneous push and correct resolve -> count stays 4; 8 resolves total drain in FIFO order across the pointer wrap.
REQ-034 The bench SHALL cover flush collision: flush=1 with res_valid=1 and push=1 on 2 queued entries -> empty=1, no enable_res pulse, counters unchanged.
REQ-035 The bench SHALL cover saturation and reset: preload to 0xFFFF, mispredict -> mispred_cnt stays 0xFFFF; assert nRST mid-stream -> all outputs 0 immediately.
